// File: rtl/aes_round_fsm_if.sv
// Handshake and datapath-control bundle between the AES round sequencer and its surroundings.
// The master modport is the sequencer; the slave modport is the slave/streamer/datapath side.
interface aes_round_fsm_if;
  logic        start_i;
  logic [15:0] n_blocks_i;
  logic [1:0]  key_len_i;
  logic        decrypt_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        kexp_step_o;
  logic [3:0]  kexp_idx_o;
  logic        dp_load_o;
  logic        dp_round_en_o;
  logic        dp_last_o;
  logic [3:0]  dp_key_idx_o;
  logic        busy_o;
  logic        done_o;

  modport master (
    input  start_i, n_blocks_i, key_len_i, decrypt_i, in_valid_i, out_ready_i,
    output in_ready_o, out_valid_o, kexp_step_o, kexp_idx_o, dp_load_o,
           dp_round_en_o, dp_last_o, dp_key_idx_o, busy_o, done_o
  );

  modport slave (
    output start_i, n_blocks_i, key_len_i, decrypt_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_valid_o, kexp_step_o, kexp_idx_o, dp_load_o,
           dp_round_en_o, dp_last_o, dp_key_idx_o, busy_o, done_o
  );
endinterface

// File: rtl/aes_round_fsm.sv
// Sequencing controller for the iterative AES round datapath: key expansion once per job,
// then load / Nr rounds / output handoff for every block of the job.
module aes_round_fsm (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            test_mode_i,
  input  logic            clear_i,
  aes_round_fsm_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    KEYEXP,
    WAIT_IN,
    ROUND,
    OUTPUT,
    TERMINATE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  kexp_cnt_q, kexp_cnt_d;
  logic [3:0]  round_cnt_q, round_cnt_d;
  logic [3:0]  nr_q, nr_d;
  logic        decrypt_q, decrypt_d;
  logic [15:0] n_blocks_q, n_blocks_d;
  logic [15:0] blk_cnt_q, blk_cnt_d;
  logic [15:0] blk_cnt_inc;

  logic        in_ready;
  logic        out_valid;
  logic        kexp_step;
  logic [3:0]  kexp_idx;
  logic        dp_load;
  logic        dp_round_en;
  logic        dp_last;
  logic [3:0]  dp_key_idx;
  logic        busy;
  logic        done;

  logic        unused_test_mode;
  assign unused_test_mode = test_mode_i;

  // The reserved key length code falls back to the AES-128 round count.
  function automatic logic [3:0] nr_of(input logic [1:0] key_len);
    case (key_len)
      2'b01:   nr_of = 4'd12;
      2'b10:   nr_of = 4'd14;
      default: nr_of = 4'd10;
    endcase
  endfunction

  // The block counter never exceeds the latched count, so a 16-bit increment cannot wrap.
  assign blk_cnt_inc = blk_cnt_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    kexp_cnt_d  = kexp_cnt_q;
    round_cnt_d = round_cnt_q;
    nr_d        = nr_q;
    decrypt_d   = decrypt_q;
    n_blocks_d  = n_blocks_q;
    blk_cnt_d   = blk_cnt_q;

    in_ready    = 1'b0;
    out_valid   = 1'b0;
    kexp_step   = 1'b0;
    kexp_idx    = 4'd0;
    dp_load     = 1'b0;
    dp_round_en = 1'b0;
    dp_last     = 1'b0;
    dp_key_idx  = 4'd0;
    busy        = (state_q != IDLE);
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          n_blocks_d = bus.n_blocks_i;
          nr_d       = nr_of(bus.key_len_i);
          decrypt_d  = bus.decrypt_i;
          blk_cnt_d  = 16'd0;
          if (bus.n_blocks_i == 16'd0) begin
            state_d = TERMINATE;
          end else begin
            state_d    = KEYEXP;
            kexp_cnt_d = 4'd1;
          end
        end
      end

      KEYEXP: begin
        kexp_step = 1'b1;
        kexp_idx  = kexp_cnt_q;
        if (kexp_cnt_q == nr_q) begin
          kexp_cnt_d = 4'd0;
          state_d    = WAIT_IN;
        end else begin
          kexp_cnt_d = kexp_cnt_q + 4'd1;
        end
      end

      // Load is the only strobe allowed to follow an input combinationally.
      WAIT_IN: begin
        in_ready = 1'b1;
        if (bus.in_valid_i) begin
          dp_load     = 1'b1;
          dp_key_idx  = decrypt_q ? nr_q : 4'd0;
          round_cnt_d = 4'd1;
          state_d     = ROUND;
        end
      end

      ROUND: begin
        dp_round_en = 1'b1;
        dp_key_idx  = decrypt_q ? (nr_q - round_cnt_q) : round_cnt_q;
        dp_last     = (round_cnt_q == nr_q);
        if (round_cnt_q == nr_q) begin
          round_cnt_d = 4'd0;
          state_d     = OUTPUT;
        end else begin
          round_cnt_d = round_cnt_q + 4'd1;
        end
      end

      OUTPUT: begin
        out_valid = 1'b1;
        if (bus.out_ready_i) begin
          blk_cnt_d = blk_cnt_inc;
          state_d   = (blk_cnt_inc == n_blocks_q) ? TERMINATE : WAIT_IN;
        end
      end

      TERMINATE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Soft clear overrides every transition and drops any in-flight block.
    if (clear_i) begin
      state_d     = IDLE;
      kexp_cnt_d  = 4'd0;
      round_cnt_d = 4'd0;
      nr_d        = 4'd0;
      decrypt_d   = 1'b0;
      n_blocks_d  = 16'd0;
      blk_cnt_d   = 16'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      kexp_cnt_q  <= 4'd0;
      round_cnt_q <= 4'd0;
      nr_q        <= 4'd0;
      decrypt_q   <= 1'b0;
      n_blocks_q  <= 16'd0;
      blk_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      kexp_cnt_q  <= kexp_cnt_d;
      round_cnt_q <= round_cnt_d;
      nr_q        <= nr_d;
      decrypt_q   <= decrypt_d;
      n_blocks_q  <= n_blocks_d;
      blk_cnt_q   <= blk_cnt_d;
    end
  end

  assign bus.in_ready_o    = in_ready;
  assign bus.out_valid_o   = out_valid;
  assign bus.kexp_step_o   = kexp_step;
  assign bus.kexp_idx_o    = kexp_idx;
  assign bus.dp_load_o     = dp_load;
  assign bus.dp_round_en_o = dp_round_en;
  assign bus.dp_last_o     = dp_last;
  assign bus.dp_key_idx_o  = dp_key_idx;
  assign bus.busy_o        = busy;
  assign bus.done_o        = done;

endmodule
